button_debouncer: RTL

//  - Consumes the WIDTH-bit synchronized button/switch vector from the 2-FF synchronizer.
//  - Produces a debounced level per channel plus a one-cycle press pulse per channel.
//  - Sits between the synchronizer and the CPU/MMIO button logic in io_circuits.
//  - Performs no synchronization itself: sync_in must already be in the clk domain.

---
 rtl/io_pkg.sv | 19 +
 rtl/edge_detector.sv | 28 ++
 rtl/button_debouncer.sv | 88 ++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared constants and width helpers for the io_circuits blocks
// (button debouncer, edge detector and friends).
package io_pkg;

  localparam int DEFAULT_SAMPLE_CNT_MAX = 25000;  // 0.5 ms at 50 MHz
  localparam int DEFAULT_PULSE_CNT_MAX  = 150;

  // A divide-by-1 sample counter still needs one bit to exist as a register.
  function automatic int sample_cnt_w(input int sample_cnt_max);
    int w;
    w = $clog2(sample_cnt_max);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int pulse_cnt_w(input int pulse_cnt_max);
    return $clog2(pulse_cnt_max + 1);
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Registers a level vector one cycle and decodes single-cycle rise/fall pulses.
// Shared by the io_circuits blocks that need press/release style events.
module edge_detector #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  logic [WIDTH-1:0] level_q;  // the debounced_q history register

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order across always blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level;
    end
  end

  assign rise_pulse = level & ~level_q;
  assign fall_pulse = ~level & level_q;

endmodule

// File: rtl/button_debouncer.sv
// Press-direction debouncer for synchronized buttons: per-channel saturating
// sample counters, a debounced level and a one-cycle press pulse per channel.
// Optional release_pulse output is enabled by `define BUTTON_DEBOUNCER_RELEASE_EN.
module button_debouncer
  import io_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = DEFAULT_SAMPLE_CNT_MAX,
  parameter int PULSE_CNT_MAX  = DEFAULT_PULSE_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] press_pulse
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
  ,
  output logic [WIDTH-1:0] release_pulse
`endif
);

  localparam int SAMPLE_CNT_W = sample_cnt_w(SAMPLE_CNT_MAX);
  localparam int PULSE_CNT_W  = pulse_cnt_w(PULSE_CNT_MAX);

  localparam logic [SAMPLE_CNT_W-1:0] SAMPLE_LAST = SAMPLE_CNT_W'(SAMPLE_CNT_MAX - 1);
  localparam logic [PULSE_CNT_W-1:0]  PULSE_FULL  = PULSE_CNT_W'(PULSE_CNT_MAX);

  logic [SAMPLE_CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic                    tick;

  // With SAMPLE_CNT_MAX == 1 the counter is pinned at 0 and tick fires every cycle.
  assign tick         = (sample_cnt_q == SAMPLE_LAST);
  assign sample_cnt_d = tick ? '0 : sample_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [PULSE_CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: cnt_d gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
      cnt_d = cnt_q;
      if (!sync_in[i]) begin
        cnt_d = '0;
      end else if (tick && (cnt_q < PULSE_FULL)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign debounced_out[i] = (cnt_q == PULSE_FULL);
  end

`ifdef BUTTON_DEBOUNCER_RELEASE_EN
  edge_detector #(.WIDTH(WIDTH)) u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .level      (debounced_out),
    .rise_pulse (press_pulse),
    .fall_pulse (release_pulse)
  );
`else
  logic [WIDTH-1:0] release_unused;

  edge_detector #(.WIDTH(WIDTH)) u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .level      (debounced_out),
    .rise_pulse (press_pulse),
    .fall_pulse (release_unused)
  );
`endif

endmodule
